// File: rtl/warp_imem_responder.sv
// warp_imem_responder: fixed-latency instruction fetch responder with
// misaligned/out-of-range fault flagging, redirect flush and a preload port.
module warp_imem_responder #(
    parameter logic [38:0] BASE_ADDR = 39'h4000000000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_imem_ren,
    input  logic [38:0]              i_imem_raddr,
    output logic                     o_imem_valid,
    output logic [63:0]              o_imem_rdata,
    output logic                     o_imem_fault,
    input  logic                     i_flush,
    input  logic                     i_load_en,
    input  logic [$clog2(DEPTH)-1:0] i_load_idx,
    input  logic [63:0]              i_load_data
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]        mem [DEPTH];
    logic [38:0]        offset;
    logic [AW-1:0]      idx;
    logic               misaligned;
    logic               oor;
    logic               fault;

    logic [LATENCY-1:0] pv;
    logic [LATENCY-1:0] pf;
    logic [63:0]        pd [LATENCY];

    // BASE_ADDR is 8-byte aligned, so offset[2:0] equals raddr[2:0].
    assign offset     = i_imem_raddr - BASE_ADDR;
    assign idx        = offset[AW+2:3];
    assign misaligned = |offset[2:0];
    assign oor        = |offset[38:AW+3];
    assign fault      = misaligned | oor;

    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_load_en) begin
            mem[i_load_idx] <= i_load_data;
        end
    end

    // Stage 0 takes the new request; flush only clears older slots.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pv <= '0;
            pf <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= i_imem_ren;
            pf[0] <= i_imem_ren & fault;
            pd[0] <= (i_imem_ren && !fault) ? mem[idx] : '0;
            for (int k = 1; k < LATENCY; k++) begin
                pv[k] <= pv[k-1] & ~i_flush;
                pf[k] <= pf[k-1] & ~i_flush;
                pd[k] <= i_flush ? '0 : pd[k-1];
            end
        end
    end

    assign o_imem_valid = pv[LATENCY-1];
    assign o_imem_fault = pf[LATENCY-1];
    assign o_imem_rdata = pd[LATENCY-1];

endmodule

// File: tb/tb_warp_imem_responder.sv
// Bench for warp_imem_responder: three latencies side by side, directed
// table plus random traffic against a stimulus-history reference model.
module tb_warp_imem_responder;
    localparam logic [38:0] B = 39'h4000000000;

    typedef struct {
        bit          rstn;
        bit          ren;
        logic [38:0] addr;
        bit          flush;
        bit          len;
        logic [9:0]  lidx;
        logic [63:0] ldata;
        bit          ev;
        bit          ef;
        logic [63:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ren = 1'b0;
    logic [38:0] raddr = '0;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [9:0]  load_idx = '0;
    logic [63:0] load_data = '0;

    logic        v1, f1, v2, f2, v3, f3;
    logic [63:0] d1, d2, d3;

    int n_cmp = 0;
    int n_fail = 0;

    logic [63:0] mm [1024];
    bit          l_acc [$];
    bit          l_kill [$];
    bit          l_fault [$];
    logic [63:0] l_data [$];
    vec_t        tv [$];

    always #5 clk = ~clk;

    warp_imem_responder #(.BASE_ADDR(B), .DEPTH(1024), .LATENCY(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_imem_ren(ren), .i_imem_raddr(raddr),
        .o_imem_valid(v1), .o_imem_rdata(d1), .o_imem_fault(f1),
        .i_flush(flush), .i_load_en(load_en), .i_load_idx(load_idx),
        .i_load_data(load_data));
    warp_imem_responder #(.BASE_ADDR(B), .DEPTH(1024), .LATENCY(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_imem_ren(ren), .i_imem_raddr(raddr),
        .o_imem_valid(v2), .o_imem_rdata(d2), .o_imem_fault(f2),
        .i_flush(flush), .i_load_en(load_en), .i_load_idx(load_idx),
        .i_load_data(load_data));
    warp_imem_responder #(.BASE_ADDR(B), .DEPTH(1024), .LATENCY(3)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_imem_ren(ren), .i_imem_raddr(raddr),
        .o_imem_valid(v3), .o_imem_rdata(d3), .o_imem_fault(f3),
        .i_flush(flush), .i_load_en(load_en), .i_load_idx(load_idx),
        .i_load_data(load_data));

    function automatic vec_t mk(bit rs, bit rn, logic [38:0] a, bit fl,
                                bit le, logic [9:0] li, logic [63:0] ld,
                                bit ev, bit ef, logic [63:0] ed);
        vec_t t;
        t.rstn = rs; t.ren = rn; t.addr = a; t.flush = fl;
        t.len = le; t.lidx = li; t.ldata = ld;
        t.ev = ev; t.ef = ef; t.ed = ed;
        return t;
    endfunction

    // Response seen after edge e for latency L comes from the request at
    // edge e-L+1, unless a flush or reset hit any later edge up to e.
    function automatic logic [65:0] model_out(int e, int lat);
        int r;
        r = e - lat + 1;
        if (r < 0) return '0;
        if (!l_acc[r]) return '0;
        for (int k = r + 1; k <= e; k++) begin
            if (l_kill[k]) return '0;
        end
        return {1'b1, l_fault[r], l_data[r]};
    endfunction

    task automatic check(string name, logic [65:0] act, logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got v=%0b f=%0b d=%h, want v=%0b f=%0b d=%h",
                     name, l_acc.size() - 1, act[65], act[64], act[63:0],
                     exp[65], exp[64], exp[63:0]);
        end
    endtask

    task automatic step(bit rs, bit rn, logic [38:0] a, bit fl,
                        bit le, logic [9:0] li, logic [63:0] ld);
        logic [38:0] off;
        bit          flt;
        int          e;
        rst_n = rs; ren = rn; raddr = a; flush = fl;
        load_en = le; load_idx = li; load_data = ld;
        @(posedge clk);
        off = a - B;
        flt = (off % 8 != 0) || (off >= 39'd8192);
        l_acc.push_back(rs && rn);
        l_kill.push_back(!rs || fl);
        l_fault.push_back(flt);
        l_data.push_back(flt ? 64'd0 : mm[off / 8]);
        if (rs && le) mm[li] = ld;
        #1;
        e = l_acc.size() - 1;
        check("lat1", {v1, f1, d1}, model_out(e, 1));
        check("lat2", {v2, f2, d2}, model_out(e, 2));
        check("lat3", {v3, f3, d3}, model_out(e, 3));
    endtask

    initial begin
        logic [63:0] w0, w2;
        logic [38:0] a;
        int          pulses, at;
        logic [63:0] pdata;

        for (int i = 0; i < 1024; i++) mm[i] = '0;
        w0 = 64'h0820611307800093;

        tv.push_back(mk(0, 0, 0,            0, 0, 0, 0,      0, 0, 0));
        tv.push_back(mk(0, 1, B,            0, 0, 0, 0,      0, 0, 0));
        tv.push_back(mk(1, 0, 0,            0, 1, 0, w0,     0, 0, 0));
        tv.push_back(mk(1, 0, 0,            0, 1, 1, 64'h11, 0, 0, 0));
        tv.push_back(mk(1, 0, 0,            0, 1, 2, 64'h22, 0, 0, 0));
        tv.push_back(mk(1, 0, 0,            0, 1, 5, 64'h0,  0, 0, 0));
        tv.push_back(mk(1, 1, B,            0, 1, 3, 64'h33, 1, 0, w0));
        tv.push_back(mk(1, 1, B + 8,        0, 0, 0, 0,      1, 0, 64'h11));
        tv.push_back(mk(1, 1, B + 16,       0, 0, 0, 0,      1, 0, 64'h22));
        tv.push_back(mk(1, 1, B + 4,        0, 0, 0, 0,      1, 1, 0));
        tv.push_back(mk(1, 1, 39'h3FFFFFFFF8, 0, 0, 0, 0,    1, 1, 0));
        tv.push_back(mk(1, 1, B + 39'h2000, 0, 0, 0, 0,      1, 1, 0));
        tv.push_back(mk(1, 1, B + 24,       0, 0, 0, 0,      1, 0, 64'h33));
        tv.push_back(mk(1, 1, B + 40,       0, 1, 5, 64'hDEADBEEFCAFEF00D,
                        1, 0, 0));
        tv.push_back(mk(1, 1, B + 40,       0, 0, 0, 0,      1, 0,
                        64'hDEADBEEFCAFEF00D));
        tv.push_back(mk(1, 0, 0,            0, 0, 0, 0,      0, 0, 0));
        tv.push_back(mk(1, 0, 0,            1, 0, 0, 0,      0, 0, 0));
        tv.push_back(mk(1, 1, B,            1, 0, 0, 0,      1, 0, w0));
        tv.push_back(mk(1, 1, B + 8,        0, 0, 0, 0,      1, 0, 64'h11));
        tv.push_back(mk(0, 0, 0,            0, 1, 1, 64'hBAD, 0, 0, 0));
        tv.push_back(mk(1, 0, 0,            0, 0, 0, 0,      0, 0, 0));
        tv.push_back(mk(1, 1, B + 8,        0, 0, 0, 0,      1, 0, 64'h11));
        tv.push_back(mk(1, 0, 0,            0, 0, 0, 0,      0, 0, 0));

        foreach (tv[i]) begin
            step(tv[i].rstn, tv[i].ren, tv[i].addr, tv[i].flush,
                 tv[i].len, tv[i].lidx, tv[i].ldata);
            check($sformatf("vec%0d", i), {v1, f1, d1},
                  {tv[i].ev, tv[i].ef, tv[i].ed});
        end

        for (int i = 0; i < 16; i++) begin
            step(1, 0, 0, 0, 1, 10'(i), {$urandom, $urandom});
        end
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 8)
                0:       a = B + 39'($urandom_range(1, 127));
                1:       a = B - 39'(8 * $urandom_range(1, 4));
                2:       a = B + 39'h2000 + 39'(8 * $urandom_range(0, 3));
                default: a = B + 39'(8 * $urandom_range(0, 15));
            endcase
            step($urandom % 40 != 0, $urandom % 4 != 0, a,
                 $urandom % 10 == 0, $urandom % 3 == 0,
                 10'($urandom % 16), {$urandom, $urandom});
        end

        step(0, 0, 0, 0, 0, 0, 0);
        w2 = mm[2];
        pulses = 0; at = -1; pdata = '0;
        step(1, 1, B,      0, 0, 0, 0);
        step(1, 1, B + 8,  0, 0, 0, 0);
        step(1, 1, B + 16, 1, 0, 0, 0);
        if (v3) begin pulses++; at = 2; pdata = d3; end
        for (int j = 3; j < 9; j++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (v3) begin pulses++; at = j; pdata = d3; end
        end
        check("flush_pulses", 66'(pulses), 66'd1);
        check("flush_edge", 66'(at), 66'd4);
        check("flush_data", {2'b00, pdata}, {2'b00, w2});

        step(1, 1, B + 8, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        pulses = 0;
        for (int j = 0; j < 5; j++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            if (v2) pulses++;
        end
        check("reset_drop", 66'(pulses), 66'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/warp_imem_responder.md
Name: warp_imem_responder

Overview:
Synthesizable instruction-memory responder for the hart's fetch port. It accepts 64-bit fetch requests (`ren`/`raddr`) and returns in-order `valid`/`rdata` responses after a fixed, parameterized latency. It flags misaligned and out-of-range fetches, and can drop in-flight responses on a fetch redirect. It sits between `warp_hart` and the instruction backing store. A side load port lets benches and boot logic preload program words.

Parameters:
- BASE_ADDR, 39'h4000000000, byte address of word 0; must be 8-byte aligned.
- DEPTH, 1024, number of 64-bit words; power of two, ≥2.
- LATENCY, 1, cycles from request to response; legal range 1..8.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_imem_ren  in  1  fetch request valid this cycle.
- i_imem_raddr  in  39  fetch byte address.
- o_imem_valid  out  1  response valid; one-cycle pulse per accepted request.
- o_imem_rdata  out  64  response data; bits [31:0] hold the instruction at raddr, bits [63:32] the instruction at raddr+4.
- o_imem_fault  out  1  response is a fault; qualified by o_imem_valid.
- i_flush  in  1  kill all requests accepted in earlier cycles.
- i_load_en  in  1  preload write enable.
- i_load_idx  in  $clog2(DEPTH)  preload word index.
- i_load_data  in  64  preload data.

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - o_imem_valid=0, o_imem_fault=0, o_imem_rdata=0.
  - All pipeline slots are cleared.
  - Memory array contents are not reset.
  - i_load_en is ignored while in reset.
- Acceptance:
  - There is no back-pressure; every cycle with i_imem_ren=1 (and i_rst_n=1) is accepted.
  - Back-to-back requests give back-to-back responses, so throughput is 1 per cycle.
- Address decode on the request cycle:
  - offset = raddr − BASE_ADDR, computed in 39-bit unsigned arithmetic (wrap on underflow).
  - idx = offset[$clog2(DEPTH)+2:3].
  - misaligned = raddr[2:0]≠0.
  - oor = offset ≥ DEPTH*8.
  - fault = misaligned | oor.
- Array read:
  - The array is read in the request cycle (read-before-write).
  - A same-cycle i_load_en to the same idx returns the old data; the new data is visible from the next request onward.
- Latency pipeline:
  - An LATENCY-deep shift of {valid, fault, data}.
  - A request accepted at edge N produces o_imem_valid=1 during cycle N+LATENCY (registered output).
  - Responses are strictly in order.
- Fault response: o_imem_valid=1, o_imem_fault=1, o_imem_rdata=0. The array is not read.
- Idle: when no response is due, o_imem_valid=0, o_imem_fault=0, o_imem_rdata=0 (data zeroed, not held).
- Flush:
  - i_flush=1 at edge N clears every valid bit of requests accepted before edge N.
  - A request presented in the same cycle as i_flush is accepted and responds normally (redirect target).
  - A flush with nothing in flight has no effect.
- Reset mid-operation: all in-flight responses are dropped; no valid pulse appears after reset deasserts unless a new request is made.
- Load port: a single write per cycle, independent of fetch; the index is always in range by width.
- Address width arithmetic: only raddr[38:0] is used; no sign extension.

Test Plan:
- Preload word 0 = {32'h08206113, 32'h07800093}, LATENCY=1; ren with raddr=39'h4000000000 at edge N → valid=1, rdata=64'h0820611307800093, fault=0 in cycle N+1; valid=0 in cycle N+2.
- LATENCY=3, words 0..3 = 64'h11..44 (distinct); four back-to-back ren at 0x4000000000, +8, +16, +24 → four consecutive valid cycles starting at N+3, data in order, no gaps.
- raddr=39'h4000000004 → valid=1, fault=1, rdata=0; raddr=39'h3FFFFFFFF8 (below base) and BASE+DEPTH*8 → fault=1; a subsequent aligned in-range fetch → fault=0 with correct data.
- LATENCY=3, issue requests at N and N+1, assert i_flush at N+2 together with a new request to BASE+16 → exactly one valid pulse, at N+5, with data of word 2.
- Load idx 5 = 64'hDEADBEEF_CAFEF00D in the same cycle as a fetch of BASE+40 (old value 0) → response 0; refetch next cycle → 64'hDEADBEEFCAFEF00D.
- LATENCY=2, request at N, assert reset at N+1 for one cycle → no valid pulse in any later cycle; outputs read 0 during and after reset.
